br_resolve: RTL and testbench



---
 rtl/rv32i_types.sv | 18 +
 rtl/br_cmp.sv | 30 +++
 rtl/br_resolve.sv | 117 +++++++++++
 tb/tb_br_resolve.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I type definitions: branch funct3 encodings and a helper that
// flags the two unused branch funct3 codes.
package rv32i_types;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_funct3_t;

    function automatic logic is_illegal_branch(input logic [2:0] funct3);
        return (funct3 == 3'b010) || (funct3 == 3'b011);
    endfunction

endpackage

// File: rtl/br_cmp.sv
// Combinational WIDTH-bit branch comparator: resolves taken/not-taken for a
// branch funct3 and flags the reserved encodings.
module br_cmp
    import rv32i_types::*;
#(
    parameter int WIDTH = 32
) (
    input  branch_funct3_t   cmpop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             br_en,
    output logic             illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        br_en   = 1'b0;
        illegal = is_illegal_branch(cmpop);
        case (cmpop)
            BEQ:     br_en = (a == b);
            BNE:     br_en = (a != b);
            BLT:     br_en = ($signed(a) <  $signed(b));
            BGE:     br_en = ($signed(a) >= $signed(b));
            BLTU:    br_en = (a <  b);
            BGEU:    br_en = (a >= b);
            default: br_en = 1'b0;
        endcase
    end

endmodule

// File: rtl/br_resolve.sv
// Registered branch-resolution stage with a one-entry valid/ready buffer,
// flush and mispredict redirect. Define BR_PERF_CNT_EN for saturating counters.
module br_resolve
    import rv32i_types::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  branch_funct3_t   cmpop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] target,
    input  logic             pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             br_en,
    output logic             mispredict,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             illegal
`ifdef BR_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mis_count
`endif
);

    typedef struct packed {
        logic             br_en;
        logic             mispredict;
        logic             illegal;
        logic [WIDTH-1:0] redirect_pc;
    } br_resolve_pkt_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } entry_state_t;

    if (WIDTH < 3 || CNT_W < 1) begin : g_param_check
        $error("br_resolve: WIDTH must be >= 3 and CNT_W >= 1");
    end

    entry_state_t    state_q, state_d;
    br_resolve_pkt_t pkt_q, pkt_d;
    logic            cmp_taken;
    logic            cmp_illegal;
    logic            accept;

    br_cmp #(.WIDTH(WIDTH)) u_cmp (
        .cmpop   (cmpop),
        .a       (a),
        .b       (b),
        .br_en   (cmp_taken),
        .illegal (cmp_illegal)
    );

    assign in_ready = (state_q == EMPTY) || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        pkt_d.br_en       = cmp_taken;
        pkt_d.illegal     = cmp_illegal;
        pkt_d.mispredict  = cmp_taken != pred_taken;
        pkt_d.redirect_pc = cmp_taken ? target : pc + WIDTH'(4);
    end

    // Flush wins over everything; a same-cycle drain plus accept replaces the entry.
    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = EMPTY;
        else if (accept)
            state_d = FULL;
        else if (out_ready)
            state_d = EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q <= EMPTY;
            // NOTE: the payload is reset too, so downstream never sees X while the entry is empty.
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept)
                pkt_q <= pkt_d;
        end
    end

    assign out_valid   = (state_q == FULL);
    assign br_en       = pkt_q.br_en;
    assign mispredict  = pkt_q.mispredict;
    assign illegal     = pkt_q.illegal;
    assign redirect_pc = pkt_q.redirect_pc;

`ifdef BR_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count  <= '0;
            mis_count <= '0;
        end else if (accept) begin
            if (br_count != '1)
                br_count <= br_count + CNT_W'(1);
            if (pkt_d.mispredict && mis_count != '1)
                mis_count <= mis_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_br_resolve.sv
// Self-checking bench for br_resolve: spec-level one-entry model compared every
// cycle, plus directed literal expectations for the key scenarios.
module tb_br_resolve;
    import rv32i_types::*;

    localparam int W    = 32;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          pred_taken = 1'b0;
    logic [2:0]    op_s = 3'b000;
    logic [W-1:0]  a = '0, b = '0, pc = '0, target = '0;
    logic          in_ready, out_valid, br_en, mispredict, illegal;
    logic [W-1:0]  redirect_pc;
`ifdef BR_PERF_CNT_EN
    logic [CW-1:0] br_count, mis_count;
`endif

    int tests = 0;
    int fails = 0;

    br_resolve #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .cmpop       (branch_funct3_t'(op_s)),
        .a           (a),
        .b           (b),
        .pc          (pc),
        .target      (target),
        .pred_taken  (pred_taken),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .br_en       (br_en),
        .mispredict  (mispredict),
        .redirect_pc (redirect_pc),
        .illegal     (illegal)
`ifdef BR_PERF_CNT_EN
        ,
        .br_count    (br_count),
        .mis_count   (mis_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic          taken;
        logic          wrong;
        logic          bad_op;
        logic [W-1:0]  next_pc;
    } expect_t;

    function automatic expect_t resolve(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic [W-1:0] p, input logic [W-1:0] t, input logic pred);
        expect_t r;
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r.bad_op = (op == 3'd2) || (op == 3'd3);
        case (op)
            3'd0:    r.taken = (x == y);
            3'd1:    r.taken = (x != y);
            3'd4:    r.taken = (sx < sy);
            3'd5:    r.taken = (sx >= sy);
            3'd6:    r.taken = ({1'b0, x} < {1'b0, y});
            3'd7:    r.taken = ({1'b0, x} >= {1'b0, y});
            default: r.taken = 1'b0;
        endcase
        r.wrong   = (r.taken != pred);
        r.next_pc = r.taken ? t : W'((longint'(p) + 4) % (longint'(1) << W));
        return r;
    endfunction

    bit      mv = 1'b0;
    expect_t mpkt;
    int      m_br = 0, m_mis = 0;

    always @(posedge clk or posedge rst) begin
        bit      can_take, took;
        expect_t r;
        if (rst) begin
            mv    = 1'b0;
            m_br  = 0;
            m_mis = 0;
        end else begin
            can_take = !mv || out_ready;
            took     = in_valid && can_take && !flush;
            r        = resolve(op_s, a, b, pc, target, pred_taken);
            if (mv && out_ready) mv = 1'b0;
            if (flush) mv = 1'b0;
            if (took) begin
                mv   = 1'b1;
                mpkt = r;
                if (m_br < CMAX) m_br++;
                if (r.wrong && m_mis < CMAX) m_mis++;
            end
        end
    end

    always @(negedge clk) begin
        check("in_ready", in_ready, !mv || out_ready);
        check("out_valid", out_valid, mv);
        if (mv) begin
            check("br_en", br_en, mpkt.taken);
            check("mispredict", mispredict, mpkt.wrong);
            check("illegal", illegal, mpkt.bad_op);
            check("redirect_pc", redirect_pc, mpkt.next_pc);
        end
`ifdef BR_PERF_CNT_EN
        check("br_count", br_count, m_br);
        check("mis_count", mis_count, m_mis);
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic cycle(input logic v, input logic [2:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] ipc, input logic [W-1:0] itg, input logic pt,
                         input logic ordy, input logic fl);
        in_valid = v; op_s = op; a = ia; b = ib; pc = ipc; target = itg;
        pred_taken = pt; out_ready = ordy; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic ov, input logic be, input logic mp,
                              input logic il, input logic [W-1:0] rp);
        check({tag, ".out_valid"}, out_valid, ov);
        check({tag, ".br_en"}, br_en, be);
        check({tag, ".mispredict"}, mispredict, mp);
        check({tag, ".illegal"}, illegal, il);
        check({tag, ".redirect_pc"}, redirect_pc, rp);
    endtask

    task automatic expect_cnt(input string tag, input int br, input int mis);
`ifdef BR_PERF_CNT_EN
        check({tag, ".br_count"}, br_count, br);
        check({tag, ".mis_count"}, mis_count, mis);
`else
        if (br < 0 || mis < 0) $display("%s: bad counter expectation", tag);
`endif
    endtask

    task automatic pulse_reset(input string tag);
        in_valid = 1'b0; flush = 1'b0;
        #2 rst = 1'b1;
        #1;
        expect_out(tag, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check({tag, ".in_ready"}, in_ready, 1'b1);
        expect_cnt(tag, 0, 0);
        #3 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #11;
        expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("reset.in_ready", in_ready, 1'b1);
        expect_cnt("reset", 0, 0);
        #1 rst = 1'b0;

        cycle(1, 3'd0, 5, 5, 32'h100, 32'h200, 0, 1, 0);
        expect_out("beq", 1, 1, 1, 0, 32'h200);
        cycle(1, 3'd4, 32'hFFFF_FFFF, 1, 32'h300, 32'h400, 0, 1, 0);
        expect_out("blt", 1, 1, 1, 0, 32'h400);
        cycle(1, 3'd6, 32'hFFFF_FFFF, 1, 32'h310, 32'h410, 0, 1, 0);
        expect_out("bltu", 1, 0, 0, 0, 32'h314);
        cycle(1, 3'd5, 32'hFFFF_FFFF, 1, 32'h320, 32'h420, 1, 1, 0);
        expect_out("bge", 1, 0, 1, 0, 32'h324);
        cycle(1, 3'd7, 32'hFFFF_FFFF, 1, 32'h330, 32'h430, 1, 1, 0);
        expect_out("bgeu", 1, 1, 0, 0, 32'h430);
        cycle(1, 3'd2, 0, 0, 32'h500, 32'h600, 1, 1, 0);
        expect_out("illegal", 1, 0, 1, 1, 32'h504);

        for (int i = 0; i < 3; i++) begin
            cycle(1, 3'd1, 1, 2, 32'h600, 32'h700, 1, 0, 0);
            expect_out("stall", 1, 0, 1, 1, 32'h504);
            check("stall.in_ready", in_ready, 1'b0);
        end
        cycle(1, 3'd1, 1, 2, 32'h600, 32'h700, 1, 1, 0);
        expect_out("drain_bne", 1, 1, 0, 0, 32'h700);
        cycle(1, 3'd0, 1, 2, 32'h800, 32'h900, 0, 1, 0);
        expect_out("b2b_beq", 1, 0, 0, 0, 32'h804);

        pulse_reset("rst1");
        for (int i = 0; i < 5; i++) begin
            cycle(1, 3'd1, 7, 8, 32'h1000 + 32'(i * 16), 32'h2000, 0, 1, 0);
            expect_out("mis_run", 1, 1, 1, 0, 32'h2000);
        end
        expect_cnt("sat", CMAX, CMAX);
        pulse_reset("rst_mid");

        cycle(1, 3'd0, 3, 3, 32'h40, 32'h80, 1, 0, 0);
        expect_out("pre_flush", 1, 1, 0, 0, 32'h80);
        expect_cnt("pre_flush", 1, 0);
        cycle(1, 3'd1, 3, 4, 32'h50, 32'h90, 0, 0, 1);
        check("flush.out_valid", out_valid, 1'b0);
        check("flush.in_ready", in_ready, 1'b1);
        expect_cnt("flush", 1, 0);
        cycle(1, 3'd0, 3, 3, 32'h44, 32'h84, 1, 0, 0);
        expect_out("refill", 1, 1, 0, 0, 32'h84);
        cycle(1, 3'd0, 1, 1, 32'h48, 32'h88, 0, 1, 1);
        check("flush_drain.out_valid", out_valid, 1'b0);
        expect_cnt("flush_drain", 2, 0);

        cycle(1, 3'd1, 9, 9, 32'hFFFF_FFFC, 32'h10, 1, 1, 0);
        expect_out("wrap", 1, 0, 1, 0, 32'h0);
        expect_cnt("wrap", 3, 1);
        cycle(0, 3'd0, 0, 0, 0, 0, 0, 1, 0);
        check("idle.out_valid", out_valid, 1'b0);
        cycle(0, 3'd0, 0, 0, 0, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
